// File: rtl/sram_axi_slave_if.sv
// rtl/sram_axi_slave_if.sv - AXI4 bus bundle between the interconnect and the SRAM bank slave
interface sram_axi_slave_if #(
    parameter int ID_W   = 8,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]   arid;
    logic [31:0]       araddr;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    logic [ID_W-1:0]   awid;
    logic [31:0]       awaddr;
    logic [3:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output arready, rid, rdata, rresp, rlast, rvalid,
        output awready, wready, bid, bresp, bvalid
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  arready, rid, rdata, rresp, rlast, rvalid,
        input  awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/sram_axi_slave.sv
// rtl/sram_axi_slave.sv - AXI4 slave front-end for one synchronous SRAM bank, one transaction at a time
// Optional round-robin AR/AW arbitration when SRAM_AXI_RR_ARB_EN is defined (default: fixed read priority).
module sram_axi_slave #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    sram_axi_slave_if.slave   axi,
    output logic              sram_cs_o,
    output logic              sram_oe_o,
    output logic [3:0]        sram_web_o,
    output logic [ADDR_W-1:0] sram_a_o,
    output logic [DATA_W-1:0] sram_di_o,
    input  logic [DATA_W-1:0] sram_do_i
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_DATA = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              ar_grant, aw_grant, ar_hs, aw_hs, w_hs, last_beat, in_idle;
    logic              rd_phase, wr_phase;

`ifdef SRAM_AXI_RR_ARB_EN
    logic last_grant_q, last_grant_d;
    // Contention goes to the channel not served last; a lone VALID is always granted.
    assign ar_grant = ~(axi.awvalid & ~last_grant_q);
    assign aw_grant = ~(axi.arvalid & last_grant_q);
`else
    assign ar_grant = 1'b1;
    assign aw_grant = ~axi.arvalid;
`endif

    // READY is forced low while rst is held so every handshake output reads 0 in reset.
    assign in_idle     = (state_q == IDLE) & ~rst;
    assign axi.arready = in_idle & ar_grant;
    assign axi.awready = in_idle & aw_grant;
    assign axi.wready  = (state_q == WR_DATA);
    assign ar_hs       = axi.arready & axi.arvalid;
    assign aw_hs       = axi.awready & axi.awvalid;
    assign w_hs        = axi.wready & axi.wvalid;
    assign last_beat   = (cnt_q == len_q);
    assign rd_phase    = (state_q == RD_REQ) | (state_q == RD_DATA);
    assign wr_phase    = (state_q == WR_DATA);

    assign axi.rvalid = (state_q == RD_DATA);
    assign axi.rdata  = axi.rvalid ? sram_do_i : '0;
    assign axi.rid    = axi.rvalid ? id_q : '0;
    assign axi.rresp  = 2'b00;
    assign axi.rlast  = axi.rvalid & last_beat;
    assign axi.bvalid = (state_q == WR_RESP);
    assign axi.bid    = axi.bvalid ? id_q : '0;
    assign axi.bresp  = (axi.bvalid & err_q) ? 2'b10 : 2'b00;

    assign sram_cs_o  = rd_phase | (wr_phase & axi.wvalid);
    assign sram_oe_o  = rd_phase;
    assign sram_web_o = w_hs ? ~axi.wstrb : 4'hF;
    assign sram_a_o   = (rd_phase | wr_phase) ? addr_q : '0;
    assign sram_di_o  = wr_phase ? axi.wdata : '0;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        err_d   = err_q;
`ifdef SRAM_AXI_RR_ARB_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    id_d    = axi.arid;
                    len_d   = axi.arlen;
                    addr_d  = axi.araddr[ADDR_W+1:2];
                    cnt_d   = 4'd0;
                    state_d = RD_REQ;
`ifdef SRAM_AXI_RR_ARB_EN
                    last_grant_d = 1'b0;
`endif
                end else if (aw_hs) begin
                    id_d    = axi.awid;
                    len_d   = axi.awlen;
                    addr_d  = axi.awaddr[ADDR_W+1:2];
                    cnt_d   = 4'd0;
                    err_d   = 1'b0;
                    state_d = WR_DATA;
`ifdef SRAM_AXI_RR_ARB_EN
                    last_grant_d = 1'b1;
`endif
                end
            end
            RD_REQ: state_d = RD_DATA;
            RD_DATA: begin
                if (axi.rready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = RD_REQ;
                    end
                end
            end
            WR_DATA: begin
                if (w_hs) begin
                    // Burst length follows the beat counter; a misplaced WLAST only flags SLVERR.
                    if (axi.wlast != last_beat) err_d = 1'b1;
                    if (last_beat) begin
                        state_d = WR_RESP;
                    end else begin
                        cnt_d  = cnt_q + 4'd1;
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            WR_RESP: if (axi.bready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
`ifdef SRAM_AXI_RR_ARB_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
`ifdef SRAM_AXI_RR_ARB_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Region decode bits, byte offset, size and burst type are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{axi.araddr[31:ADDR_W+2], axi.araddr[1:0], axi.arsize, axi.arburst,
                           axi.awaddr[31:ADDR_W+2], axi.awaddr[1:0], axi.awsize, axi.awburst};
endmodule

// File: tb/tb_sram_axi_slave.sv
// tb/tb_sram_axi_slave.sv - directed table-driven bench for sram_axi_slave with a behavioural SRAM
module tb_sram_axi_slave;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_axi_slave_if #(.ID_W(8), .DATA_W(32)) axi ();

    logic        sram_cs, sram_oe;
    logic [3:0]  sram_web;
    logic [13:0] sram_a;
    logic [31:0] sram_di, sram_do;

    sram_axi_slave #(.ID_W(8), .ADDR_W(14), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .axi(axi),
        .sram_cs_o(sram_cs), .sram_oe_o(sram_oe), .sram_web_o(sram_web),
        .sram_a_o(sram_a), .sram_di_o(sram_di), .sram_do_i(sram_do)
    );

    logic [31:0] mem [0:16383] = '{default: 32'h0};
    logic        pre_en = 1'b0;
    logic [13:0] pre_a = '0;
    logic [31:0] pre_d = '0;

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_a] <= pre_d;
        end else if (sram_cs) begin
            for (int b = 0; b < 4; b++)
                if (!sram_web[b]) mem[sram_a][8*b +: 8] <= sram_di[8*b +: 8];
            if (sram_oe) sram_do <= mem[sram_a];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [13:0] a, input logic [31:0] d);
        pre_en = 1'b1; pre_a = a; pre_d = d;
        step();
        pre_en = 1'b0;
    endtask

    task automatic do_ar(input logic [31:0] addr, input logic [3:0] len, input logic [7:0] id,
                         input logic [1:0] burst);
        int n = 0;
        axi.araddr = addr; axi.arlen = len; axi.arid = id; axi.arsize = 3'd2; axi.arburst = burst;
        axi.arvalid = 1'b1;
        while (!axi.arready && n < 50) begin step(); n++; end
        chk("arready", axi.arready, 1);
        step();
        axi.arvalid = 1'b0;
        chk("rd_latency_t1", axi.rvalid, 0);
    endtask

    task automatic rd_beats(input logic [3:0] len, input logic [7:0] id, input logic [31:0] exp_d [16],
                            input int stall_beat, input int stall_cyc);
        for (int i = 0; i <= int'(len); i++) begin
            int n = 0;
            while (!axi.rvalid && n < 50) begin step(); n++; end
            chk("rvalid", axi.rvalid, 1);
            chk("rdata", axi.rdata, exp_d[i]);
            chk("rid", axi.rid, id);
            chk("rresp", axi.rresp, 0);
            chk("rlast", axi.rlast, (i == int'(len)) ? 1 : 0);
            if (i == stall_beat) begin
                for (int k = 0; k < stall_cyc; k++) begin
                    step();
                    chk("rvalid_stall", axi.rvalid, 1);
                    chk("rdata_stall", axi.rdata, exp_d[i]);
                end
            end
            axi.rready = 1'b1;
            step();
            axi.rready = 1'b0;
        end
    endtask

    task automatic do_aw(input logic [31:0] addr, input logic [3:0] len, input logic [7:0] id);
        int n = 0;
        axi.awaddr = addr; axi.awlen = len; axi.awid = id; axi.awsize = 3'd2; axi.awburst = 2'b01;
        axi.awvalid = 1'b1;
        while (!axi.awready && n < 50) begin step(); n++; end
        chk("awready", axi.awready, 1);
        step();
        axi.awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        int n = 0;
        axi.wdata = d; axi.wstrb = s; axi.wlast = l; axi.wvalid = 1'b1;
        while (!axi.wready && n < 50) begin step(); n++; end
        chk("wready", axi.wready, 1);
        step();
        axi.wvalid = 1'b0;
    endtask

    task automatic b_resp(input logic [7:0] id, input logic [1:0] resp);
        int n = 0;
        axi.bready = 1'b1;
        while (!axi.bvalid && n < 50) begin step(); n++; end
        chk("bvalid", axi.bvalid, 1);
        chk("bid", axi.bid, id);
        chk("bresp", axi.bresp, resp);
        step();
        axi.bready = 1'b0;
        chk("bvalid_drop", axi.bvalid, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_arready"}, axi.arready, 0);
        chk({tag, "_awready"}, axi.awready, 0);
        chk({tag, "_wready"}, axi.wready, 0);
        chk({tag, "_rvalid"}, axi.rvalid, 0);
        chk({tag, "_bvalid"}, axi.bvalid, 0);
        chk({tag, "_rdata"}, axi.rdata, 0);
        chk({tag, "_rid_bid"}, {axi.rid, axi.bid}, 0);
        chk({tag, "_resp_last"}, {axi.rresp, axi.bresp, axi.rlast}, 0);
        chk({tag, "_cs_oe"}, {sram_cs, sram_oe}, 0);
        chk({tag, "_web"}, sram_web, 4'hF);
        chk({tag, "_a"}, sram_a, 0);
        chk({tag, "_di"}, sram_di, 0);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [7:0]  id;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [13:0] word;
        logic [31:0] exp;
    } vec_t;

    vec_t        vt [8];
    logic [31:0] e [16];
    bit          exp_g [2];
    bit          g;

    initial begin
        vt[0] = '{1'b0, 32'h0000_0040, 8'h12, 32'h0,         4'h0, 14'h0010, 32'hDEAD_BEEF};
        vt[1] = '{1'b1, 32'h0000_0008, 8'h5A, 32'h1122_3344, 4'h4, 14'h0002, 32'h0022_0000};
        vt[2] = '{1'b1, 32'h0000_0008, 8'h5B, 32'hAABB_CCDD, 4'h3, 14'h0002, 32'h0022_CCDD};
        vt[3] = '{1'b1, 32'h0000_0008, 8'h5C, 32'hFFFF_FFFF, 4'h0, 14'h0002, 32'h0022_CCDD};
        vt[4] = '{1'b0, 32'h0000_0008, 8'h33, 32'h0,         4'h0, 14'h0002, 32'h0022_CCDD};
        vt[5] = '{1'b0, 32'hFFFF_0047, 8'h34, 32'h0,         4'h0, 14'h0011, 32'h1234_5678};
        vt[6] = '{1'b1, 32'h0001_0003, 8'h35, 32'hCAFE_F00D, 4'hF, 14'h0000, 32'hCAFE_F00D};
        vt[7] = '{1'b0, 32'h0000_0000, 8'h36, 32'h0,         4'h0, 14'h0000, 32'hCAFE_F00D};

        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
        axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0;
        axi.arvalid = 1'b0; axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        axi.rready = 1'b0; axi.bready = 1'b0;

        rst = 1'b1;
        step();
        axi.arvalid = 1'b1;
        #1;
        chk_reset_outputs("reset");
        axi.arvalid = 1'b0;
        rst = 1'b0;
        step();
        chk("idle_arready", axi.arready, 1);
        chk("idle_awready", axi.awready, 1);

        preload(14'h0010, 32'hDEAD_BEEF);
        preload(14'h0011, 32'h1234_5678);

        for (int i = 0; i < 8; i++) begin
            if (!vt[i].wr) begin
                do_ar(vt[i].addr, 4'd0, vt[i].id, 2'b01);
                step();
                chk("rd_latency_t2", axi.rvalid, 1);
                e = '{default: 32'h0};
                e[0] = vt[i].exp;
                rd_beats(4'd0, vt[i].id, e, -1, 0);
            end else begin
                do_aw(vt[i].addr, 4'd0, vt[i].id);
                w_beat(vt[i].wdata, vt[i].wstrb, 1'b1);
                b_resp(vt[i].id, 2'b00);
                chk("wr_mem", mem[vt[i].word], vt[i].exp);
            end
        end

        // 4-beat read, burst type 0 still incrementing, stalled 3 cycles on the second beat
        for (int i = 0; i < 4; i++) preload(14'h0040 + 14'(i), 32'hA000_0000 + 32'(i));
        do_ar(32'h0000_0100, 4'd3, 8'h77, 2'b00);
        e = '{default: 32'h0};
        for (int i = 0; i < 4; i++) e[i] = 32'hA000_0000 + 32'(i);
        rd_beats(4'd3, 8'h77, e, 1, 3);

        // Early WLAST: both beats land, response is SLVERR
        do_aw(32'h0000_0200, 4'd1, 8'h66);
        w_beat(32'h0102_0304, 4'hF, 1'b1);
        w_beat(32'h0506_0708, 4'hF, 1'b1);
        b_resp(8'h66, 2'b10);
        chk("wlast_mem0", mem[14'h0080], 32'h0102_0304);
        chk("wlast_mem1", mem[14'h0081], 32'h0506_0708);
        chk("wlast_mem2", mem[14'h0082], 32'h0);

        // Address wrap from the top word to word 0
        preload(14'h3FFF, 32'h0BAD_F00D);
        do_ar(32'h0000_FFFC, 4'd1, 8'h09, 2'b01);
        e = '{default: 32'h0};
        e[0] = 32'h0BAD_F00D;
        e[1] = 32'hCAFE_F00D;
        rd_beats(4'd1, 8'h09, e, -1, 0);

        // Simultaneous AR and AW, twice back-to-back
`ifdef SRAM_AXI_RR_ARB_EN
        exp_g[0] = 1'b1; exp_g[1] = 1'b0;
`else
        exp_g[0] = 1'b0; exp_g[1] = 1'b0;
`endif
        axi.araddr = 32'h40; axi.arlen = 4'd0; axi.arid = 8'h21; axi.arburst = 2'b01;
        axi.awaddr = 32'h300; axi.awlen = 4'd0; axi.awid = 8'h22; axi.awburst = 2'b01;
        for (int r = 0; r < 2; r++) begin
            int n = 0;
            axi.arvalid = 1'b1;
            axi.awvalid = 1'b1;
            #1;
            while (!(axi.arready | axi.awready) && n < 50) begin step(); n++; end
            chk("arb_exclusive", {axi.arready, axi.awready} == 2'b11, 0);
            g = axi.awready;
            chk("arb_grant", g, exp_g[r]);
            step();
            if (g) begin
                axi.awvalid = 1'b0;
                w_beat(32'h55AA_55AA, 4'hF, 1'b1);
                b_resp(8'h22, 2'b00);
                chk("arb_wr_mem", mem[14'h00C0], 32'h55AA_55AA);
            end else begin
                axi.arvalid = 1'b0;
                e = '{default: 32'h0};
                e[0] = 32'hDEAD_BEEF;
                rd_beats(4'd0, 8'h21, e, -1, 0);
            end
        end
        axi.arvalid = 1'b0;
        axi.awvalid = 1'b0;
        step();

        // Reset during beat 2 of a 4-beat write
        do_aw(32'h0000_0400, 4'd3, 8'h44);
        w_beat(32'h1111_1111, 4'hF, 1'b0);
        axi.wdata = 32'h2222_2222; axi.wstrb = 4'hF; axi.wlast = 1'b0; axi.wvalid = 1'b1;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst_async");
        step();
        chk_reset_outputs("midrst_next");
        axi.wvalid = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("midrst_no_b", axi.bvalid, 0);
        chk("midrst_no_r", axi.rvalid, 0);
        chk("midrst_mem0", mem[14'h0100], 32'h1111_1111);
        chk("midrst_mem1", mem[14'h0101], 32'h0);

        do_ar(32'h0000_0400, 4'd0, 8'h45, 2'b01);
        e = '{default: 32'h0};
        e[0] = 32'h1111_1111;
        rd_beats(4'd0, 8'h45, e, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
